// File: rtl/mc10_vram_arbiter_if.sv
// Requester-side bus of the MC-10 video RAM arbiter: VDG fetch strobe/data and CPU request/ack.
// The arbiter connects through the slave modport; the VDG/CPU side uses the master modport.
interface mc10_vram_arbiter_if #(
  parameter int RAM_AW = 12
);
  logic              vdg_ena;
  logic [12:0]       vdg_addr;
  logic [7:0]        vdg_data;
  logic              vdg_valid;
  logic              vdg_overrun;
  logic              cpu_req;
  logic              cpu_we;
  logic [RAM_AW-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;
  logic              cpu_ack;

  modport slave (
    input  vdg_ena, vdg_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output vdg_data, vdg_valid, vdg_overrun, cpu_rdata, cpu_ack
  );

  modport master (
    output vdg_ena, vdg_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  vdg_data, vdg_valid, vdg_overrun, cpu_rdata, cpu_ack
  );
endinterface

// File: rtl/mc10_vram_arbiter.sv
// Single-port video RAM arbiter: one access at a time, VDG first, CPU promoted after
// CPU_MAX_WAIT cycles of waiting. Every RAM-side signal is registered.
module mc10_vram_arbiter #(
  parameter int RAM_AW       = 12,
  parameter int CPU_MAX_WAIT = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  mc10_vram_arbiter_if.slave  bus,
  output logic [RAM_AW-1:0]   o_ram_addr,
  output logic                o_ram_we,
  output logic [7:0]          o_ram_wdata,
  input  logic [7:0]          i_ram_rdata
);

  localparam int WAIT_W = $clog2(CPU_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VDG_RD,
    S_VDG_CAP,
    S_CPU_RD,
    S_CPU_CAP,
    S_CPU_WR
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_vdg_grant;
  logic              w_cpu_grant;
  logic              w_cpu_eligible;

  logic              r_vdg_pend;
  logic [RAM_AW-1:0] r_vdg_addr;
  logic              r_vdg_overrun;
  logic [7:0]        r_vdg_data;
  logic              r_vdg_valid;
  logic [WAIT_W-1:0] r_cpu_wait;
  logic [7:0]        r_cpu_rdata;
  logic              r_cpu_ack;
  logic [RAM_AW-1:0] r_ram_addr;
  logic              r_ram_we;
  logic [7:0]        r_ram_wdata;

  // Fetch address bits above the RAM width are dropped: the VDG address wraps.
  if (RAM_AW < 13) begin : g_vdg_hi
    logic w_unused_vdg_hi;
    assign w_unused_vdg_hi = ^bus.vdg_addr[12:RAM_AW];
  end

  // A request seen while its own ack is still high is the tail of the old one.
  assign w_cpu_eligible = bus.cpu_req && !r_cpu_ack;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    w_next      = r_state;
    w_vdg_grant = 1'b0;
    w_cpu_grant = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cpu_eligible && (r_cpu_wait >= WAIT_MAX)) w_cpu_grant = 1'b1;
        else if (r_vdg_pend)                            w_vdg_grant = 1'b1;
        else if (w_cpu_eligible)                        w_cpu_grant = 1'b1;

        if (w_cpu_grant)      w_next = bus.cpu_we ? S_CPU_WR : S_CPU_RD;
        else if (w_vdg_grant) w_next = S_VDG_RD;
      end
      S_VDG_RD:  w_next = S_VDG_CAP;
      S_VDG_CAP: w_next = S_IDLE;
      S_CPU_RD:  w_next = S_CPU_CAP;
      S_CPU_CAP: w_next = S_IDLE;
      S_CPU_WR:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // NOTE: every datapath flop is cleared by reset so an abandoned access leaves no trace.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vdg_pend    <= 1'b0;
      r_vdg_addr    <= '0;
      r_vdg_overrun <= 1'b0;
      r_vdg_data    <= '0;
      r_vdg_valid   <= 1'b0;
      r_cpu_wait    <= '0;
      r_cpu_rdata   <= '0;
      r_cpu_ack     <= 1'b0;
      r_ram_addr    <= '0;
      r_ram_we      <= 1'b0;
      r_ram_wdata   <= '0;
    end else begin
      // A new strobe always wins over clearing; it only counts as an overrun
      // if the address it replaces was never handed to the RAM.
      if (bus.vdg_ena) begin
        r_vdg_pend <= 1'b1;
        r_vdg_addr <= bus.vdg_addr[RAM_AW-1:0];
        if (r_vdg_pend && !w_vdg_grant) r_vdg_overrun <= 1'b1;
      end else if (w_vdg_grant) begin
        r_vdg_pend <= 1'b0;
      end

      if (!bus.cpu_req || w_cpu_grant) r_cpu_wait <= '0;
      else if (r_cpu_wait != WAIT_MAX) r_cpu_wait <= r_cpu_wait + 1'b1;

      r_ram_we <= 1'b0;
      if (w_vdg_grant) r_ram_addr <= r_vdg_addr;
      if (w_cpu_grant) begin
        r_ram_addr <= bus.cpu_addr;
        if (bus.cpu_we) begin
          r_ram_we    <= 1'b1;
          r_ram_wdata <= bus.cpu_wdata;
        end
      end

      r_vdg_valid <= (r_state == S_VDG_CAP);
      if (r_state == S_VDG_CAP) r_vdg_data <= i_ram_rdata;

      r_cpu_ack <= (r_state == S_CPU_CAP) || (r_state == S_CPU_WR);
      if (r_state == S_CPU_CAP) r_cpu_rdata <= i_ram_rdata;
    end
  end

  assign bus.vdg_data    = r_vdg_data;
  assign bus.vdg_valid   = r_vdg_valid;
  assign bus.vdg_overrun = r_vdg_overrun;
  assign bus.cpu_rdata   = r_cpu_rdata;
  assign bus.cpu_ack     = r_cpu_ack;
  assign o_ram_addr      = r_ram_addr;
  assign o_ram_we        = r_ram_we;
  assign o_ram_wdata     = r_ram_wdata;

endmodule

// File: tb/tb_mc10_vram_arbiter.sv
// Scoreboard bench for mc10_vram_arbiter: stimulus pushes expected VDG bytes and CPU
// completions, a negedge monitor pops them as vdg_valid / cpu_ack appear.
module tb_mc10_vram_arbiter;
  localparam int RAM_AW       = 12;
  localparam int CPU_MAX_WAIT = 8;

  typedef struct packed {
    logic       is_rd;
    logic [7:0] data;
  } cpu_exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mc10_vram_arbiter_if #(.RAM_AW(RAM_AW)) bus ();
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  mc10_vram_arbiter #(
    .RAM_AW       (RAM_AW),
    .CPU_MAX_WAIT (CPU_MAX_WAIT)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .bus         (bus),
    .o_ram_addr  (ram_addr),
    .o_ram_we    (ram_we),
    .o_ram_wdata (ram_wdata),
    .i_ram_rdata (ram_rdata)
  );

  // Synchronous RAM model; unwritten locations return a fixed preload table.
  logic [7:0] mem     [0:(1<<RAM_AW)-1];
  bit         written [0:(1<<RAM_AW)-1];

  function automatic logic [7:0] init_val(input logic [RAM_AW-1:0] a);
    case (a)
      12'h123: return 8'h5A;
      12'h010: return 8'h11;
      12'h200: return 8'h3C;
      12'h345: return 8'h77;
      12'h400: return 8'h40;
      12'h403: return 8'h43;
      12'h406: return 8'h46;
      12'h409: return 8'h49;
      12'h40C: return 8'h4C;
      12'h500: return 8'h55;
      12'hABC: return 8'hBC;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr]     <= ram_wdata;
      written[ram_addr] <= 1'b1;
    end
    ram_rdata <= written[ram_addr] ? mem[ram_addr] : init_val(ram_addr);
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int vdg_seen_cyc = -1;
  int ack_seen_cyc = -1;
  logic [7:0] vdg_q [$];
  cpu_exp_t   cpu_q [$];
  logic [7:0] exp_t4 [5] = '{8'h40, 8'h43, 8'h46, 8'h49, 8'h4C};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic cpu_exp_t mk_exp(input logic is_rd, input logic [7:0] d);
    cpu_exp_t e;
    e.is_rd = is_rd;
    e.data  = d;
    return e;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ram"}, {ram_addr, ram_we, ram_wdata}, 32'h0);
    check({tag, "_vdg"}, {bus.vdg_data, bus.vdg_valid, bus.vdg_overrun}, 32'h0);
    check({tag, "_cpu"}, {bus.cpu_rdata, bus.cpu_ack}, 32'h0);
  endtask

  // Single uncontended fetch: address on the RAM at c+2, data valid at c+4 for one cycle.
  task automatic vdg_fetch(input logic [12:0] a, input logic [11:0] exp_ra,
                           input logic [7:0] exp_d, input string name);
    bus.vdg_ena  = 1'b1;
    bus.vdg_addr = a;
    vdg_q.push_back(exp_d);
    tick();
    bus.vdg_ena = 1'b0;
    tick();
    check({name, "_ram_addr"}, ram_addr, exp_ra);
    tick();
    check({name, "_valid_early"}, bus.vdg_valid, 0);
    tick();
    check({name, "_valid"}, bus.vdg_valid, 1);
    tick();
    check({name, "_valid_1cyc"}, bus.vdg_valid, 0);
    check({name, "_data_held"}, bus.vdg_data, exp_d);
  endtask

  // Latency counts cycles with cpu_req high, the ack cycle included.
  task automatic cpu_access(input logic we, input logic [11:0] addr, input logic [7:0] wd,
                            input logic [7:0] exp_rd, input int exp_lat, input string name);
    int n;
    int we_cycles;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    cpu_q.push_back(mk_exp(!we, exp_rd));
    n = 1;
    we_cycles = 0;
    while (!bus.cpu_ack && n < 40) begin
      tick();
      n++;
      if (ram_we) we_cycles++;
    end
    bus.cpu_req = 1'b0;
    check({name, "_lat"}, n, exp_lat);
    if (we) check({name, "_we_cycles"}, we_cycles, 1);
    tick();
  endtask

  initial begin
    logic [7:0] ev;
    cpu_exp_t   ce;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.vdg_valid) begin
          vdg_seen_cyc = cyc;
          if (vdg_q.size() == 0) check("vdg_unexpected_valid", bus.vdg_valid, 0);
          else begin
            ev = vdg_q.pop_front();
            check("vdg_data", bus.vdg_data, ev);
          end
        end
        if (bus.cpu_ack) begin
          ack_seen_cyc = cyc;
          if (cpu_q.size() == 0) check("cpu_unexpected_ack", bus.cpu_ack, 0);
          else begin
            ce = cpu_q.pop_front();
            if (ce.is_rd) check("cpu_rdata", bus.cpu_rdata, ce.data);
            else          check("cpu_wr_we_drop", ram_we, 0);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k_ack;
    bus.vdg_ena   = 1'b0;
    bus.vdg_addr  = '0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;

    // T1: reset state, idle state, then a plain fetch.
    reset = 1'b1;
    repeat (3) tick();
    check_all_zero("rst");
    reset = 1'b0;
    repeat (2) tick();
    check_all_zero("idle");
    vdg_fetch(13'h0123, 12'h123, 8'h5A, "t1");

    // T2: write then read back the top address.
    repeat (2) tick();
    cpu_access(1'b1, 12'hFFF, 8'hA5, 8'h00, 3, "t2_wr");
    cpu_access(1'b0, 12'hFFF, 8'h00, 8'hA5, 4, "t2_rd");

    // T3: both requests rise together while a fetch is in flight; the VDG wins the next IDLE.
    repeat (2) tick();
    bus.vdg_ena  = 1'b1;
    bus.vdg_addr = 13'h0010;
    vdg_q.push_back(8'h11);
    tick();
    bus.vdg_ena = 1'b0;
    tick();
    bus.vdg_ena   = 1'b1;
    bus.vdg_addr  = 13'h0200;
    vdg_q.push_back(8'h3C);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 12'h345;
    cpu_q.push_back(mk_exp(1'b1, 8'h77));
    tick();
    bus.vdg_ena = 1'b0;
    n = 2;
    while (!bus.cpu_ack && n < 40) begin
      tick();
      n++;
    end
    bus.cpu_req = 1'b0;
    check("t3_lat", n, 9);
    tick();
    check("t3_vdg_first", vdg_seen_cyc < ack_seen_cyc, 1);

    // T4: fetches every 3 cycles starve the CPU until cpu_wait reaches CPU_MAX_WAIT.
    repeat (3) tick();
    check("t4_pre_overrun", bus.vdg_overrun, 0);
    k_ack = -1;
    for (int k = 0; k < 20; k++) begin
      if ((k % 3 == 0) && (k <= 12)) begin
        bus.vdg_ena  = 1'b1;
        bus.vdg_addr = 13'(16'h0400 + k);
        if (k != 9) vdg_q.push_back(exp_t4[k/3]);
      end else begin
        bus.vdg_ena = 1'b0;
      end
      if (k == 1) begin
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 12'h500;
        cpu_q.push_back(mk_exp(1'b1, 8'h55));
      end
      if (bus.cpu_ack && (k_ack < 0)) begin
        k_ack = k;
        bus.cpu_req = 1'b0;
      end
      tick();
    end
    bus.vdg_ena = 1'b0;
    check("t4_ack_cycle", k_ack, 13);
    check("t4_overrun", bus.vdg_overrun, 1);

    // T5: the top fetch address bit wraps away.
    vdg_fetch(13'h1ABC, 12'hABC, 8'hBC, "t5");
    check("t5_overrun_sticky", bus.vdg_overrun, 1);

    // T6: reset lands in CPU_CAP; the read is dropped, then re-issued.
    repeat (2) tick();
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 12'h345;
    tick();
    tick();
    check("t6_cap_addr", ram_addr, 12'h345);
    reset       = 1'b1;
    bus.cpu_req = 1'b0;
    tick();
    check_all_zero("t6_after_rst");
    reset = 1'b0;
    tick();
    cpu_access(1'b0, 12'h345, 8'h00, 8'h77, 4, "t6_rd");

    repeat (5) tick();
    check("sb_vdg_empty", vdg_q.size(), 0);
    check("sb_cpu_empty", cpu_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
